// File: rtl/sevenseg_counter_mux.sv
// Multi-digit BCD/hex up/down counter with a time-multiplexed seven-segment driver.
// Define SEVENSEG_LZB_EN to blank leading zero digits on the display.
`timescale 1ns/1ps

module sevenseg_digit (
  input  logic [3:0] d,
  input  logic       step,
  input  logic       up,
  input  logic       bcd,
  output logic [3:0] nd,
  output logic       carry
);
  always_comb begin
    nd    = d;
    carry = 1'b0;
    if (step) begin
      if (up) begin
        // An illegal BCD digit counts as max, so it rolls to 0 with carry.
        if ((bcd && d >= 4'd9) || d == 4'hF) begin
          nd    = 4'd0;
          carry = 1'b1;
        end else begin
          nd = d + 4'd1;
        end
      end else begin
        if (d == 4'd0) begin
          nd    = bcd ? 4'd9 : 4'hF;
          carry = 1'b1;
        end else if (bcd && d > 4'd9) begin
          nd = 4'd9;
        end else begin
          nd = d - 4'd1;
        end
      end
    end
  end
endmodule

module sevenseg_counter_mux #(
  parameter int CLK_HZ  = 10_000_000,
  parameter int TICK_HZ = 1,
  parameter int DIGITS  = 4,
  parameter int SCAN_HZ = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  bcd_mode,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tick_out,
  output logic                  wrap,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     dig_sel
);
  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int SDIV = CLK_HZ / (SCAN_HZ * DIGITS);
  localparam int PW   = $clog2(DIV);
  localparam int SW   = (SDIV > 1) ? $clog2(SDIV) : 1;
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam logic [SW-1:0] SMAX = SW'(SDIV - 1);
  localparam logic [IW-1:0] IMAX = IW'(DIGITS - 1);

  logic [DIGITS-1:0][3:0] cnt, nxt, ld;
  logic [DIGITS:0]        carry;
  logic [PW-1:0]          presc;
  logic [SW-1:0]          sdiv;
  logic [IW-1:0]          idx;
  logic [DIGITS-1:0]      blank;
  logic                   tick;

  function automatic logic [7:0] font(input logic [3:0] d);
    case (d)
      4'h0: font = 8'hC0;  4'h1: font = 8'hF9;  4'h2: font = 8'hA4;  4'h3: font = 8'hB0;
      4'h4: font = 8'h99;  4'h5: font = 8'h92;  4'h6: font = 8'h82;  4'h7: font = 8'hF8;
      4'h8: font = 8'h80;  4'h9: font = 8'h90;  4'hA: font = 8'h88;  4'hB: font = 8'h83;
      4'hC: font = 8'hC6;  4'hD: font = 8'hA1;  4'hE: font = 8'h86;  default: font = 8'h8E;
    endcase
  endfunction

  // Ripple carry/borrow chain; the top digit's carry-out is the wrap condition.
  assign carry[0] = 1'b1;
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    sevenseg_digit u_dig (
      .d     (cnt[i]),
      .step  (carry[i]),
      .up    (up_dn),
      .bcd   (bcd_mode),
      .nd    (nxt[i]),
      .carry (carry[i+1])
    );
    assign ld[i] = (bcd_mode && load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
  end

  assign tick  = en && (presc == PMAX);
  assign count = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      presc    <= '0;
      tick_out <= 1'b0;
      wrap     <= 1'b0;
    end else if (load) begin
      cnt      <= ld;
      presc    <= '0;
      tick_out <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      tick_out <= tick;
      wrap     <= tick & carry[DIGITS];
      if (en)   presc <= (presc == PMAX) ? '0 : presc + 1'b1;
      if (tick) cnt   <= nxt;
    end
  end

  always_comb begin
    blank = '0;
`ifdef SEVENSEG_LZB_EN
    begin
      logic zero_above;
      zero_above = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
        zero_above = zero_above & (cnt[i] == 4'd0);
        blank[i]   = zero_above;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdiv    <= '0;
      idx     <= '0;
      seg     <= 8'hFF;
      dig_sel <= '1;
    end else begin
      if (sdiv == SMAX) begin
        sdiv <= '0;
        idx  <= (idx == IMAX) ? '0 : idx + 1'b1;
      end else begin
        sdiv <= sdiv + 1'b1;
      end
      seg     <= blank[idx] ? 8'hFF : font(cnt[idx]);
      dig_sel <= ~(DIGITS'(1) << idx);
    end
  end
endmodule

// File: tb/tb_sevenseg_counter_mux.sv
// Scoreboard bench for sevenseg_counter_mux: expected ticks are queued with their cycle offset.
`timescale 1ns/1ps

module tb_sevenseg_counter_mux;
  logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, up_dn = 1'b1, bcd_mode = 1'b1, load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [7:0] count, seg;
  logic       tick_out, wrap;
  logic [1:0] dig_sel;

  typedef struct {
    logic [7:0] cnt;
    logic       wr;
    int         at;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  sevenseg_counter_mux #(.CLK_HZ(100), .TICK_HZ(10), .DIGITS(2), .SCAN_HZ(10)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .bcd_mode(bcd_mode),
    .load(load), .load_val(load_val), .count(count), .tick_out(tick_out),
    .wrap(wrap), .seg(seg), .dig_sel(dig_sel)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] c, input logic w, input int at);
    exp_t e;
    e.cnt = c; e.wr = w; e.at = at;
    sb.push_back(e);
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1; load_val = v;
    step();
    load = 1'b0;
  endtask

  // Runs n cycles, matching every tick_out against the head of the scoreboard.
  task automatic run_cycles(input int n, input string tag);
    exp_t e;
    for (int i = 1; i <= n; i++) begin
      step();
      if (tick_out) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL %s unexpected tick at cycle %0d count=%h", tag, i, count);
        end else begin
          e = sb.pop_front();
          if (count !== e.cnt || wrap !== e.wr || i != e.at) begin
            fails++;
            $display("FAIL %s tick: got count=%h wrap=%b cycle=%0d, want count=%h wrap=%b cycle=%0d",
                     tag, count, wrap, i, e.cnt, e.wr, e.at);
          end
        end
      end else if (wrap !== 1'b0) begin
        tests++; fails++;
        $display("FAIL %s wrap without tick at cycle %0d", tag, i);
      end
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      tests++; fails++;
      $display("FAIL %s missing tick: want count=%h at cycle %0d", tag, e.cnt, e.at);
    end
  endtask

  task automatic test_reset();
    step();
    tests++;
    if (count !== 8'h00 || tick_out !== 1'b0 || wrap !== 1'b0 || seg !== 8'hFF || dig_sel !== 2'b11) begin
      fails++;
      $display("FAIL reset: got count=%h tick=%b wrap=%b seg=%h sel=%b, want 00 0 0 ff 11",
               count, tick_out, wrap, seg, dig_sel);
    end
    rst_n = 1'b1;
    step();
    tests++;
    if (seg !== 8'hC0 || dig_sel !== 2'b10) begin
      fails++;
      $display("FAIL first_scan: got seg=%h sel=%b, want c0 10", seg, dig_sel);
    end
  endtask

  task automatic test_count();
    en = 1'b1; up_dn = 1'b1; bcd_mode = 1'b1;
    for (int k = 1; k <= 10; k++) push(8'(((k / 10) << 4) | (k % 10)), 1'b0, 10 * k);
    run_cycles(100, "count_up_bcd");
    tests++;
    if (count !== 8'h10) begin
      fails++;
      $display("FAIL count_final: got %h want 10", count);
    end
  endtask

  task automatic test_wrap();
    en = 1'b1;
    up_dn = 1'b1; bcd_mode = 1'b1; do_load(8'h99); push(8'h00, 1'b1, 10); run_cycles(10, "wrap_up_bcd");
    bcd_mode = 1'b0; do_load(8'hFF); push(8'h00, 1'b1, 10); run_cycles(10, "wrap_up_hex");
    do_load(8'h0F); push(8'h10, 1'b0, 10); run_cycles(10, "carry_up_hex");
    up_dn = 1'b0; bcd_mode = 1'b1; do_load(8'h00); push(8'h99, 1'b1, 10); run_cycles(10, "wrap_dn_bcd");
    do_load(8'h40); push(8'h39, 1'b0, 10); run_cycles(10, "borrow_dn_bcd");
    bcd_mode = 1'b0; do_load(8'h00); push(8'hFF, 1'b1, 10); run_cycles(10, "wrap_dn_hex");
  endtask

  task automatic test_load();
    en = 1'b1; up_dn = 1'b1; bcd_mode = 1'b1;
    do_load(8'hAB);
    tests++;
    if (count !== 8'h99) begin
      fails++;
      $display("FAIL load_clamp: got %h want 99", count);
    end
    do_load(8'h12);
    run_cycles(9, "pre_collide");
    load = 1'b1; load_val = 8'h45;
    step();
    load = 1'b0;
    tests++;
    if (count !== 8'h45 || tick_out !== 1'b0 || wrap !== 1'b0) begin
      fails++;
      $display("FAIL load_vs_tick: got count=%h tick=%b wrap=%b, want 45 0 0", count, tick_out, wrap);
    end
    push(8'h46, 1'b0, 10);
    run_cycles(10, "post_collide");
  endtask

  task automatic test_scan();
    logic [1:0] prev;
    int         last;
    logic [7:0] want;
    en = 1'b0;
    do_load(8'h37);
    step();
    prev = dig_sel; last = -1;
    for (int i = 1; i <= 30; i++) begin
      step();
      want = (dig_sel == 2'b10) ? 8'hF8 : (dig_sel == 2'b01) ? 8'hB0 : 8'h00;
      tests++;
      if (seg !== want) begin
        fails++;
        $display("FAIL scan_seg: got seg=%h sel=%b want seg=%h", seg, dig_sel, want);
      end
      if (dig_sel !== prev) begin
        if (last >= 0) begin
          tests++;
          if (i - last != 5) begin
            fails++;
            $display("FAIL scan_period: got %0d cycles want 5", i - last);
          end
        end
        last = i; prev = dig_sel;
      end
    end
    tests++;
    if (last < 0) begin
      fails++;
      $display("FAIL scan_static: dig_sel stuck at %b", dig_sel);
    end
`ifdef SEVENSEG_LZB_EN
    do_load(8'h05); step();
    for (int i = 0; i < 10; i++) begin
      step();
      want = (dig_sel == 2'b10) ? 8'h92 : 8'hFF;
      tests++;
      if (seg !== want) begin fails++; $display("FAIL lzb_05: got seg=%h sel=%b want %h", seg, dig_sel, want); end
    end
`else
    do_load(8'h05); step();
    for (int i = 0; i < 10; i++) begin
      step();
      want = (dig_sel == 2'b10) ? 8'h92 : 8'hC0;
      tests++;
      if (seg !== want) begin fails++; $display("FAIL nolzb_05: got seg=%h sel=%b want %h", seg, dig_sel, want); end
    end
`endif
    do_load(8'h50); step();
    for (int i = 0; i < 10; i++) begin
      step();
      want = (dig_sel == 2'b10) ? 8'hC0 : 8'h92;
      tests++;
      if (seg !== want) begin fails++; $display("FAIL digit0_zero: got seg=%h sel=%b want %h", seg, dig_sel, want); end
    end
  endtask

  task automatic test_async_reset();
    en = 1'b1; up_dn = 1'b1; bcd_mode = 1'b1;
    do_load(8'h27);
    run_cycles(3, "pre_reset");
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (count !== 8'h00 || seg !== 8'hFF || dig_sel !== 2'b11 || tick_out !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got count=%h seg=%h sel=%b tick=%b, want 00 ff 11 0",
               count, seg, dig_sel, tick_out);
    end
    rst_n = 1'b1;
    step();
    tests++;
    if (seg !== 8'hC0 || dig_sel !== 2'b10) begin
      fails++;
      $display("FAIL post_reset_scan: got seg=%h sel=%b want c0 10", seg, dig_sel);
    end
  endtask

  task automatic test_freeze();
    en = 1'b1; up_dn = 1'b1; bcd_mode = 1'b1;
    do_load(8'h23);
    run_cycles(4, "pre_freeze");
    en = 1'b0;
    run_cycles(50, "frozen");
    tests++;
    if (count !== 8'h23) begin
      fails++;
      $display("FAIL freeze_count: got %h want 23", count);
    end
    en = 1'b1;
    push(8'h24, 1'b0, 6);
    run_cycles(6, "resume");
  endtask

  initial begin
    test_reset();
    test_count();
    test_wrap();
    test_load();
    test_scan();
    test_async_reset();
    test_freeze();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
